// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - shared TLB op encodings, sequencer states and field widths
package tlb_pkg;

  localparam int TLB_IDX_W   = 6;
  localparam int TLB_ASID_W  = 10;
  localparam int TLB_VPN_W   = 19;
  localparam int TLB_INVOP_W = 5;

  typedef enum logic [2:0] {
    TLB_OP_SRCH = 3'd0,
    TLB_OP_RD   = 3'd1,
    TLB_OP_WR   = 3'd2,
    TLB_OP_FILL = 3'd3,
    TLB_OP_INV  = 3'd4
  } tlb_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } tlb_state_e;

  // Query ops return a response; all other legal ops modify the TLB and need a drain.
  function automatic logic op_is_query(input logic [2:0] t);
    return (t == TLB_OP_SRCH) || (t == TLB_OP_RD);
  endfunction

  function automatic logic op_is_legal(input logic [2:0] t);
    return t <= TLB_OP_INV;
  endfunction

endpackage

// File: rtl/tlb_op_cnt.sv
// rtl/tlb_op_cnt.sv - 4-bit loadable down-counter with zero flag
// Saturates at zero so a stray decrement never wraps.
module tlb_op_cnt (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [3:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/tlb_op_ctrl.sv
// rtl/tlb_op_ctrl.sv - TLB maintenance op sequencer (strobe, wait, response / drain + refetch)
// Optional TLB_OP_PERF_EN adds issued-op and INVTLB counters.
module tlb_op_ctrl
  import tlb_pkg::*;
#(
  parameter int unsigned WAIT_CYC  = 1,
  parameter int unsigned DRAIN_CYC = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_op_vld,
  output logic                   o_op_rdy,
  input  logic [2:0]             i_op_type,
  input  logic [TLB_INVOP_W-1:0] i_inv_op,
  input  logic [TLB_ASID_W-1:0]  i_inv_asid,
  input  logic [TLB_VPN_W-1:0]   i_inv_va,
  output logic                   o_tlbsrch,
  output logic                   o_tlbrd,
  output logic                   o_tlbwr,
  output logic                   o_tlbfill,
  output logic                   o_invtlb,
  output logic [TLB_INVOP_W-1:0] o_invtlb_op,
  output logic [TLB_ASID_W-1:0]  o_invtlb_asid,
  output logic [TLB_VPN_W-1:0]   o_invtlb_va,
  input  logic                   i_srch_hit,
  input  logic [TLB_IDX_W-1:0]   i_srch_idx,
  input  logic                   i_rd_en,
  output logic                   o_resp_vld,
  input  logic                   i_resp_rdy,
  output logic                   o_resp_hit,
  output logic [TLB_IDX_W-1:0]   o_resp_idx,
  output logic                   o_resp_rd_en,
  output logic                   o_fetch_block,
  output logic                   o_refetch_req
`ifdef TLB_OP_PERF_EN
  ,
  output logic [31:0]            o_perf_ops,
  output logic [31:0]            o_perf_inv
`endif
);

  tlb_state_e              r_state;
  tlb_state_e              w_next;
  logic [2:0]              r_type;
  logic [TLB_INVOP_W-1:0]  r_inv_op;
  logic [TLB_ASID_W-1:0]   r_inv_asid;
  logic [TLB_VPN_W-1:0]    r_inv_va;
  logic                    r_resp_hit;
  logic [TLB_IDX_W-1:0]    r_resp_idx;
  logic                    r_resp_rd_en;
  logic                    w_accept;
  logic                    w_wait_zero;
  logic                    w_drain_zero;
  logic                    w_sample;

  // Gating with rst_n keeps op_rdy (and so fetch_block) low while reset is held.
  assign o_op_rdy = (r_state == ST_IDLE) && i_rst_n;
  assign w_accept = i_op_vld && o_op_rdy;
  assign w_sample = (r_state == ST_WAIT) && w_wait_zero;

  tlb_op_cnt u_wait_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (r_state == ST_ISSUE),
    .i_load_val (4'(WAIT_CYC - 1)),
    .i_dec      (r_state == ST_WAIT),
    .o_zero     (w_wait_zero)
  );

  tlb_op_cnt u_drain_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_sample),
    .i_load_val (4'(DRAIN_CYC - 1)),
    .i_dec      (r_state == ST_DRAIN),
    .o_zero     (w_drain_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_ISSUE;
      ST_ISSUE: w_next = op_is_legal(r_type) ? ST_WAIT : ST_IDLE;
      ST_WAIT:  if (w_wait_zero) w_next = op_is_query(r_type) ? ST_RESP : ST_DRAIN;
      ST_RESP:  if (i_resp_rdy) w_next = ST_IDLE;
      ST_DRAIN: if (w_drain_zero) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_tlbsrch     = 1'b0;
    o_tlbrd       = 1'b0;
    o_tlbwr       = 1'b0;
    o_tlbfill     = 1'b0;
    o_invtlb      = 1'b0;
    if (r_state == ST_ISSUE) begin
      case (r_type)
        TLB_OP_SRCH: o_tlbsrch = 1'b1;
        TLB_OP_RD:   o_tlbrd   = 1'b1;
        TLB_OP_WR:   o_tlbwr   = 1'b1;
        TLB_OP_FILL: o_tlbfill = 1'b1;
        TLB_OP_INV:  o_invtlb  = 1'b1;
        default:     ;
      endcase
    end
    o_resp_vld    = (r_state == ST_RESP);
    o_refetch_req = (r_state == ST_DRAIN) && w_drain_zero;
    o_fetch_block = (r_state != ST_IDLE) || w_accept;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_type       <= 3'd0;
      r_inv_op     <= '0;
      r_inv_asid   <= '0;
      r_inv_va     <= '0;
      r_resp_hit   <= 1'b0;
      r_resp_idx   <= '0;
      r_resp_rd_en <= 1'b0;
    end else begin
      if (w_accept) begin
        r_type     <= i_op_type;
        r_inv_op   <= i_inv_op;
        r_inv_asid <= i_inv_asid;
        r_inv_va   <= i_inv_va;
      end
      if (w_sample && op_is_query(r_type)) begin
        r_resp_hit   <= i_srch_hit;
        r_resp_idx   <= i_srch_idx;
        r_resp_rd_en <= i_rd_en;
      end
    end
  end

  // Operands are forwarded in the accept cycle so they are valid from accept onward.
  assign o_invtlb_op   = w_accept ? i_inv_op   : r_inv_op;
  assign o_invtlb_asid = w_accept ? i_inv_asid : r_inv_asid;
  assign o_invtlb_va   = w_accept ? i_inv_va   : r_inv_va;
  assign o_resp_hit    = r_resp_hit;
  assign o_resp_idx    = r_resp_idx;
  assign o_resp_rd_en  = r_resp_rd_en;

`ifdef TLB_OP_PERF_EN
  logic [31:0] r_perf_ops;
  logic [31:0] r_perf_inv;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_ops <= 32'd0;
      r_perf_inv <= 32'd0;
    end else if (r_state == ST_ISSUE) begin
      if (op_is_legal(r_type)) r_perf_ops <= r_perf_ops + 32'd1;
      if (r_type == TLB_OP_INV) r_perf_inv <= r_perf_inv + 32'd1;
    end
  end

  assign o_perf_ops = r_perf_ops;
  assign o_perf_inv = r_perf_inv;
`endif

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Sequencer for TLB maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) issued from the commit stage to the 64-entry TLB. It accepts one committed op at a time over a valid/ready handshake and drives exactly one single-cycle strobe into the TLB. It blocks instruction-fetch lookups while the op is in flight and returns search/read results over a response handshake. After write-type ops it holds fetch for a drain window, then requests a refetch.

## Interface
- `WAIT_CYC`, 1: cycles between strobe and result sample/completion; legal range 1..15.
- `DRAIN_CYC`, 2: fetch-block cycles after write-type ops; legal range 1..15.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `op_vld` in 1: commit presents an op.
- `op_rdy` out 1: controller can accept.
- `op_type` in 3: 0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; 5..7 reserved.
- `inv_op` in 5, `inv_asid` in 10, `inv_va` in 19 ([31:13]): INVTLB operands, latched on accept.
- `tlbsrch`, `tlbrd`, `tlbwr`, `tlbfill`, `invtlb` out 1 each: one-cycle strobes to the TLB.
- `invtlb_op` out 5, `invtlb_asid` out 10, `invtlb_va` out 19: latched INV operands, stable from accept until return to IDLE.
- `srch_hit` in 1, `srch_idx` in 6, `rd_en` in 1: TLB search/read results.
- `resp_vld` out 1, `resp_rdy` in 1: result handshake.
- `resp_hit` out 1, `resp_idx` out 6, `resp_rd_en` out 1: registered results.
- `fetch_block` out 1: gates the TLB fetch lookup (IF_stage_vld).
- `refetch_req` out 1: one-cycle pulse at the end of drain.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - `op_rdy`=1.
  - Accept on `op_vld & op_rdy`: latch type and INV operands, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Assert the strobe matching the latched type.
  - Reserved types assert no strobe and return to IDLE with no response and no refetch.
  - Otherwise go to WAIT and load the wait counter with `WAIT_CYC`-1.
- WAIT:
  - Count down.
  - At count 0: SRCH/RD register `srch_hit`, `srch_idx`, `rd_en` into the resp fields and go to RESP; WR/FILL/INV load the drain counter with `DRAIN_CYC`-1 and go to DRAIN.
- RESP:
  - `resp_vld`=1 with fields held stable.
  - On `resp_rdy`, go to IDLE.
  - No timeout.
- DRAIN:
  - Count down.
  - At count 0, pulse `refetch_req` and go to IDLE.
- `fetch_block` = (state != IDLE); it is also asserted combinationally in the accept cycle (`op_vld & op_rdy`).
- Strobes are mutually exclusive and only ever high in ISSUE.
- Resp fields of RD are `resp_rd_en` only; `resp_hit`/`resp_idx` are don't-care for RD but hold the sampled value.
- Reset: async entry to IDLE. All strobes, `resp_vld`, `refetch_req` and `fetch_block` are 0 immediately. `op_rdy`=1 after reset release. Latched operands and resp fields reset to 0. Reset mid-op abandons the op with no strobe replay.

## Timing
- Accept at edge T0:
  - ISSUE during cycle T0+1 (strobe high).
  - WAIT for `WAIT_CYC` cycles.
  - SRCH/RD: `resp_vld` first high in cycle T0+2+`WAIT_CYC` (T0+3 at defaults).
  - WR/FILL/INV: `refetch_req` in cycle T0+1+`WAIT_CYC`+`DRAIN_CYC` (T0+4 at defaults); `op_rdy` returns the next cycle.
- Back-to-back: `op_rdy` is 0 from the cycle after accept until IDLE is re-entered; no accept in the same cycle a response handshake completes.
- `resp_rdy` held high at RESP entry: one-cycle RESP.

## Configuration
- `TLB_OP_PERF_EN` defined:
  - Adds `perf_ops` out 32 (ops issued, counts ISSUE cycles with a strobe).
  - Adds `perf_inv` out 32 (INVTLB count).
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: ports and counters absent; behaviour is otherwise identical.

## Structure
- Shared package `tlb_pkg`: op_type encodings (`TLB_OP_SRCH`..`TLB_OP_INV`), FSM state enum, `TLB_IDX_W`=6, `TLB_ASID_W`=10, `TLB_VPN_W`=19.
- One sub-module, `tlb_op_cnt`: 4-bit loadable down-counter with a zero flag, instanced for both wait and drain.

## Test plan
- Reset mid-WAIT of an INV op → all strobes/`fetch_block`/`refetch_req` 0 asynchronously; `op_rdy`=1 after release; no `invtlb` pulse afterwards.
- SRCH with TLB returning hit=1, idx=37 at defaults → `tlbsrch` high only in T0+1; `resp_vld` at T0+3 with `resp_hit`=1, `resp_idx`=37; `fetch_block` high T0..T0+3.
- RD with `resp_rdy` low for 5 cycles → `resp_vld` and fields stable all 5 cycles; `op_rdy` stays 0; IDLE the cycle after `resp_rdy`.
- INV with op=5, asid=0x2A, va=0x1234 → `invtlb`=1 at T0+1; operands stable T0..T0+4; `refetch_req` single pulse at T0+4.
- `WAIT_CYC`=3, `DRAIN_CYC`=4, FILL → `tlbfill` at T0+1, `refetch_req` at T0+8, `op_rdy`=1 at T0+9.
- Reserved op_type=6 → no strobe, no `resp_vld`, no `refetch_req`; `op_rdy`=1 at T0+2; with `TLB_OP_PERF_EN`, `perf_ops` unchanged.
